regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the fixed 2-read/1-write regfile.
- Sits between decode (read) and writeback (write).
- Adds configurable width, depth and port counts, and multiple write ports with priority.
- Adds write-to-read bypass on every read port and a per-register busy scoreboard for hazard detection.
- Adds a post-reset init sequencer that zeroes the array, so the array itself needs no reset.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 4.
- AW, log2(DEPTH), register address width.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high once initialisation has completed.
- we  in  NWR  per-write-port enable.
- waddr  in  NWR*AW  write addresses, port i at bits [i*AW +: AW].
- wdata  in  NWR*DW  write data, port i at bits [i*DW +: DW].
- re  in  NRD  per-read-port enable.
- raddr  in  NRD*AW  read addresses, packed the same way.
- rdata  out  NRD*DW  read data (combinational).
- rbusy  out  NRD  busy flag of each read port's addressed register (combinational).
- issue_we  in  1  marks a register as having a pending producer.
- issue_addr  in  AW  register being issued.

Behaviour:
- Reset:
  - rst high, asynchronously and at any time (including mid-init or mid-run): state=INIT, init_ptr=1, ready=0, busy[all]=0.
  - While rst is high: rdata=0 and rbusy=0 on all ports.
  - Array contents are not reset directly.
- FSM states: INIT and RUN.
  - INIT: each cycle writes 0 to regs[init_ptr], then init_ptr increments.
  - On the cycle that writes DEPTH-1, the state moves to RUN.
  - ready=1 from the first RUN cycle, so ready rises exactly DEPTH-1 rising edges after rst deasserts.
  - In INIT: we and issue_we are ignored, rdata=0, rbusy=0.
  - RUN persists until rst.
- Writes (RUN only):
  - At the clock edge, regs[waddr_i] <= wdata_i for every i with we_i=1 and waddr_i!=0.
  - If several enabled ports target the same address, the highest-index port wins.
  - Address 0 is never written and always reads 0.
- Reads (RUN, combinational, zero latency), evaluated per port j in this priority:
  - re_j=0 -> 0.
  - raddr_j=0 -> 0.
  - Any enabled write port i with waddr_i==raddr_j -> wdata of the highest-index such port (bypass).
  - Otherwise -> regs[raddr_j].
  - Each port is driven only by its own address and enable; no cross-port mixing.
- Scoreboard (RUN only):
  - busy[DEPTH] register; busy[0] is hard-wired to 0.
  - At the edge, any enabled write to address a clears busy[a].
  - At the same edge, issue_we=1 with issue_addr=a (a!=0) sets busy[a].
  - Set and clear on the same address in the same cycle: set wins, since the new producer supersedes the old.
  - rbusy_j = re_j and busy[raddr_j] and not (an enabled write to raddr_j this cycle). A same-cycle write resolves the hazard through bypass.
- Width rules:
  - init_ptr is AW bits and is never wrapped past DEPTH-1.
  - No arithmetic on data; data passes through unmodified.

Decomposition:
- Shared package/defines file holds:
  - RstEnable=1'b1, WriteEnable=1'b1, ReadEnable=1'b1.
  - ZeroWord.
  - Default DW/DEPTH/AW.
  - State encodings ST_INIT / ST_RUN.
- One sub-module, regfile_rd_port, instantiated NRD times via generate. It implements the zero/bypass/array select and the rbusy qualification for a single read port.
- Storage, write logic, scoreboard and FSM remain in regfile_mp.

Test Plan:
- Init timing: assert rst for 3 cycles, release, DEPTH=32 -> ready=0 for 31 edges and 1 after. Then read r5 on port 0 -> rdata=0.
- Write then read: write r3=0xDEADBEEF on port 0, next cycle read r3 on ports 0 and 1 -> both return 0xDEADBEEF.
- Write priority and bypass: same cycle, port 0 writes r7=0x11111111 and port 1 writes r7=0x22222222, with read of r7 -> rdata=0x22222222 immediately; next cycle, a read of r7 still returns 0x22222222.
- r0 protection: write r0=0xFFFFFFFF with a same-cycle read of r0 -> rdata=0, and reading r0 on the next cycle -> 0.
- Scoreboard sequence on r9:
  - issue r9 -> next cycle rbusy=1.
  - Same cycle write r9=0x5 plus read -> rbusy=0, rdata=0x5.
  - Issue r9 and write r9 in the same cycle -> busy stays 1 afterwards.
- Mid-run reset: write r4=0xA5A5A5A5 with busy[4] set, then pulse rst asynchronously between edges -> ready, rdata and rbusy drop to 0 immediately. After re-init, r4 reads 0 and rbusy=0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants, default sizing and FSM encoding for the multi-port register file.
package regfile_mp_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    localparam logic [DW_DEF-1:0] ZeroWord = '0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: zero/bypass/array select plus busy qualification.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int NWR = 2
) (
    input  logic              en,
    input  logic [AW-1:0]     raddr,
    input  logic [DW-1:0]     arr_data,
    input  logic              busy_bit,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR*DW-1:0] wdata,
    output logic [DW-1:0]     rdata,
    output logic              rbusy
);

    logic          hit;
    logic [DW-1:0] byp;

    // Ascending scan so the highest-index matching writer is the one forwarded.
    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int i = 0; i < NWR; i++) begin
            if (we[i] == WriteEnable && waddr[i*AW +: AW] == raddr) begin
                hit = 1'b1;
                byp = wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        if (en != ReadEnable)
            rdata = '0;
        else if (raddr == '0)
            rdata = '0;
        else if (hit)
            rdata = byp;
        else
            rdata = arr_data;
    end

    // A same-cycle writer resolves the hazard through the bypass path.
    assign rbusy = (en == ReadEnable) && busy_bit && !hit;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write priority, read bypass,
// busy scoreboard and a post-reset zeroing sequencer.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR*DW-1:0] wdata,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              issue_we,
    input  logic [AW-1:0]     issue_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e                  state, state_nxt;
    logic [AW-1:0]           init_ptr;
    logic [DW-1:0]           regs [DEPTH];
    logic [DEPTH-1:0]        busy;
    logic [NWR-1:0]          we_run;
    logic [NRD-1:0]          re_run;
    logic [NRD-1:0][DW-1:0]  arr_rd;
    logic [NRD-1:0]          busy_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_ptr == LAST)
            state_nxt = ST_RUN;
    end

    always_comb begin
        ready = (state == ST_RUN);
    end

    // Pointer parks on the last register so it never wraps back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable)
            init_ptr <= AW'(1);
        else if (state == ST_INIT && init_ptr != LAST)
            init_ptr <= init_ptr + AW'(1);
    end

    // Array has no reset; the sequencer clears it register by register.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            regs[init_ptr] <= DW'(ZeroWord);
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] == WriteEnable && waddr[i*AW +: AW] != '0)
                    regs[waddr[i*AW +: AW]] <= wdata[i*DW +: DW];
            end
        end
    end

    // Issue is applied after the write clears so a new producer wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            busy <= '0;
        end else if (state == ST_RUN) begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] == WriteEnable)
                    busy[waddr[i*AW +: AW]] <= 1'b0;
            end
            if (issue_we == WriteEnable && issue_addr != '0)
                busy[issue_addr] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    assign we_run = ready ? we : '0;
    assign re_run = ready ? re : '0;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        assign arr_rd[j]  = regs[raddr[j*AW +: AW]];
        assign busy_rd[j] = busy[raddr[j*AW +: AW]];

        regfile_rd_port #(
            .DW  (DW),
            .AW  (AW),
            .NWR (NWR)
        ) u_rd (
            .en       (re_run[j]),
            .raddr    (raddr[j*AW +: AW]),
            .arr_data (arr_rd[j]),
            .busy_bit (busy_rd[j]),
            .we       (we_run),
            .waddr    (waddr),
            .wdata    (wdata),
            .rdata    (rdata[j*DW +: DW]),
            .rbusy    (rbusy[j])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array/scoreboard reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic              clk;
    logic              rst;
    logic              ready;
    logic [NWR-1:0]    we;
    logic [NWR*AW-1:0] waddr;
    logic [NWR*DW-1:0] wdata;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              issue_we;
    logic [AW-1:0]     issue_addr;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] mregs [DEPTH];
    bit            mbusy [DEPTH];

    regfile_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .re         (re),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .issue_we   (issue_we),
        .issue_addr (issue_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_hit(input logic [AW-1:0] a, output logic [DW-1:0] d);
        m_hit = 1'b0;
        d = '0;
        for (int i = 0; i < NWR; i++)
            if (we[i] && waddr[i*AW +: AW] == a) begin
                m_hit = 1'b1;
                d = wdata[i*DW +: DW];
            end
    endfunction

    function automatic logic [DW-1:0] m_rdata(input int j);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = raddr[j*AW +: AW];
        if (!re[j] || a == '0) return '0;
        if (m_hit(a, d)) return d;
        return mregs[a];
    endfunction

    function automatic logic m_rbusy(input int j);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = raddr[j*AW +: AW];
        if (!re[j] || a == '0) return 1'b0;
        return mbusy[a] && !m_hit(a, d);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < DEPTH; k++) begin
            mregs[k] = '0;
            mbusy[k] = 1'b0;
        end
    endtask

    task automatic m_tick();
        for (int i = 0; i < NWR; i++)
            if (we[i]) begin
                if (waddr[i*AW +: AW] != '0) mregs[waddr[i*AW +: AW]] = wdata[i*DW +: DW];
                mbusy[waddr[i*AW +: AW]] = 1'b0;
            end
        if (issue_we && issue_addr != '0) mbusy[issue_addr] = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        we = '0; waddr = '0; wdata = '0;
        re = '0; raddr = '0;
        issue_we = 1'b0; issue_addr = '0;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i] = 1'b1;
        waddr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic set_rd(input int j, input logic [AW-1:0] a);
        re[j] = 1'b1;
        raddr[j*AW +: AW] = a;
    endtask

    // model update, then advance to the next falling edge
    task automatic tick();
        m_tick();
        @(posedge clk);
        @(negedge clk);
        clear_in();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_rd(0, 5'd3); set_rd(1, 5'd9);
        #1;
        n_chk++;
        if (ready !== 1'b0 || rdata !== '0 || rbusy !== '0) begin
            n_fail++;
            $display("FAIL in_reset: ready=%b rdata=%h rbusy=%b, want 0/0/0", ready, rdata, rbusy);
        end
        @(negedge clk);
        rst = 1'b0;
        // writes/issues during INIT must be ignored and not bypassed
        clear_in();
        set_wr(0, 5'd6, 32'h12345678); set_wr(1, 5'd10, 32'h9ABCDEF0);
        issue_we = 1'b1; issue_addr = 5'd6;
        set_rd(0, 5'd6);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (ready !== (k >= 31)) begin
                n_fail++;
                $display("FAIL init_ready edge %0d: ready=%b want %b", k, ready, (k >= 31));
            end
            if (k == 20) begin
                we = '0; issue_we = 1'b0;
            end
            n_chk++;
            if (rdata[0 +: DW] !== '0 || rbusy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL init_read edge %0d: rdata=%h rbusy=%b want 0/0", k, rdata[0 +: DW], rbusy[0]);
            end
        end
        @(negedge clk);
        clear_in();
        set_rd(0, 5'd5); set_rd(1, 5'd10);
        #1;
        n_chk++;
        if (rdata[0 +: DW] !== 32'h0 || rdata[DW +: DW] !== 32'h0) begin
            n_fail++;
            $display("FAIL post_init_read: got %h/%h want 0/0", rdata[0 +: DW], rdata[DW +: DW]);
        end
        tick();
    endtask

    task automatic test_write_read();
        set_wr(0, 5'd3, 32'hDEADBEEF);
        tick();
        set_rd(0, 5'd3); set_rd(1, 5'd3);
        #1;
        n_chk++;
        if (rdata[0 +: DW] !== 32'hDEADBEEF || rdata[DW +: DW] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read: got %h/%h want deadbeef", rdata[0 +: DW], rdata[DW +: DW]);
        end
        tick();
    endtask

    task automatic test_priority_bypass();
        set_wr(0, 5'd7, 32'h11111111); set_wr(1, 5'd7, 32'h22222222);
        set_rd(0, 5'd7); set_rd(1, 5'd3);
        #1;
        n_chk++;
        if (rdata[0 +: DW] !== 32'h22222222) begin
            n_fail++;
            $display("FAIL prio_bypass: got %h want 22222222", rdata[0 +: DW]);
        end
        n_chk++;
        if (rdata[DW +: DW] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL port_isolation: got %h want deadbeef", rdata[DW +: DW]);
        end
        tick();
        set_rd(0, 5'd7); set_rd(1, 5'd7);
        #1;
        n_chk++;
        if (rdata[0 +: DW] !== 32'h22222222 || rdata[DW +: DW] !== 32'h22222222) begin
            n_fail++;
            $display("FAIL prio_stored: got %h/%h want 22222222", rdata[0 +: DW], rdata[DW +: DW]);
        end
        tick();
    endtask

    task automatic test_r0();
        set_wr(1, 5'd0, 32'hFFFFFFFF);
        set_rd(0, 5'd0); set_rd(1, 5'd0);
        #1;
        n_chk++;
        if (rdata !== '0) begin
            n_fail++;
            $display("FAIL r0_bypass: got %h want 0", rdata);
        end
        tick();
        set_rd(0, 5'd0);
        #1;
        n_chk++;
        if (rdata[0 +: DW] !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_stored: got %h want 0", rdata[0 +: DW]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        issue_we = 1'b1; issue_addr = 5'd9;
        set_rd(0, 5'd9);
        #1;
        n_chk++;
        if (rbusy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_issue_same: rbusy=%b want 0", rbusy[0]);
        end
        tick();
        set_rd(0, 5'd9); set_rd(1, 5'd9); re[1] = 1'b0;
        #1;
        n_chk++;
        if (rbusy !== 2'b01) begin
            n_fail++;
            $display("FAIL sb_busy: rbusy=%b want 01", rbusy);
        end
        tick();
        set_wr(0, 5'd9, 32'h5);
        set_rd(0, 5'd9);
        #1;
        n_chk++;
        if (rbusy[0] !== 1'b0 || rdata[0 +: DW] !== 32'h5) begin
            n_fail++;
            $display("FAIL sb_write_bypass: rbusy=%b rdata=%h want 0/5", rbusy[0], rdata[0 +: DW]);
        end
        tick();
        set_rd(0, 5'd9);
        #1;
        n_chk++;
        if (rbusy[0] !== 1'b0 || rdata[0 +: DW] !== 32'h5) begin
            n_fail++;
            $display("FAIL sb_cleared: rbusy=%b rdata=%h want 0/5", rbusy[0], rdata[0 +: DW]);
        end
        tick();
        issue_we = 1'b1; issue_addr = 5'd9;
        set_wr(1, 5'd9, 32'h66);
        tick();
        set_rd(1, 5'd9);
        #1;
        n_chk++;
        if (rbusy[1] !== 1'b1 || rdata[DW +: DW] !== 32'h66) begin
            n_fail++;
            $display("FAIL sb_set_wins: rbusy=%b rdata=%h want 1/66", rbusy[1], rdata[DW +: DW]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NWR; i++) begin
                a = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) set_wr(i, a, $urandom);
            end
            for (int j = 0; j < NRD; j++) begin
                a = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 7));
                raddr[j*AW +: AW] = a;
                re[j] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 2) == 0) begin
                issue_we = 1'b1;
                issue_addr = AW'($urandom_range(0, 7));
            end
            #1;
            for (int j = 0; j < NRD; j++) begin
                n_chk++;
                if (rdata[j*DW +: DW] !== m_rdata(j) || rbusy[j] !== m_rbusy(j)) begin
                    n_fail++;
                    $display("FAIL rand c%0d p%0d: rdata=%h rbusy=%b want %h/%b",
                             c, j, rdata[j*DW +: DW], rbusy[j], m_rdata(j), m_rbusy(j));
                end
            end
            tick();
        end
    endtask

    task automatic test_midrun_reset();
        set_wr(0, 5'd4, 32'hA5A5A5A5);
        issue_we = 1'b1; issue_addr = 5'd4;
        tick();
        set_rd(0, 5'd4);
        #1;
        n_chk++;
        if (rdata[0 +: DW] !== 32'hA5A5A5A5 || rbusy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst: rdata=%h rbusy=%b want a5a5a5a5/1", rdata[0 +: DW], rbusy[0]);
        end
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (ready !== 1'b0 || rdata[0 +: DW] !== 32'h0 || rbusy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: ready=%b rdata=%h rbusy=%b want 0/0/0", ready, rdata[0 +: DW], rbusy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_in();
        m_reset();
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            if (k == 30 || k == 31) begin
                n_chk++;
                if (ready !== (k == 31)) begin
                    n_fail++;
                    $display("FAIL reinit_ready edge %0d: ready=%b want %b", k, ready, (k == 31));
                end
            end
        end
        @(negedge clk);
        set_rd(0, 5'd4); set_rd(1, 5'd4);
        #1;
        n_chk++;
        if (rdata !== '0 || rbusy !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reinit r4: rdata=%h rbusy=%b want 0/00", rdata, rbusy);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority_bypass();
        test_r0();
        test_scoreboard();
        test_random();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
